proc_trace_buf: RTL
===================

Name: proc_trace_buf

Overview:
- Downstream consumer of the proc core's per-cycle execution stream (op_code, alu_out).
- Captures qualifying cycles into a stamped trace FIFO and exposes them on a valid/ready drain port, for a UART or debug reader.
- Provides in hardware the per-cycle op_code/alu log the simulation bench writes to file, so traces survive on silicon and FPGA.
- Flags and counts lost entries when the drain stalls.

Parameters:
OPCODE_WIDTH, 5, op_code width; tied to the global OPCODE_WIDTH at instantiation
VALUE_WIDTH, 8, alu_out width; tied to the global VALUE_WIDTH
DEPTH, 16, FIFO entries; power of two, >= 2
SEQ_WIDTH, 16, sequence stamp width; wraps modulo 2^SEQ_WIDTH
DROP_WIDTH, 8, drop counter width; saturating
FILTER_NOP, 1, 1 = cycles with op_code == NOP_CODE are not sampled
NOP_CODE, 0, op_code value treated as no-op

Ports:
clk  in  1  rising-edge clock shared with proc
rst  in  1  synchronous, active-high reset
trace_en  in  1  sampling enable
clr  in  1  synchronous flush; same effect as rst on all state
op_code  in  OPCODE_WIDTH  from proc
alu_out  in  VALUE_WIDTH  from proc
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_seq  out  SEQ_WIDTH  head entry sequence stamp
out_op  out  OPCODE_WIDTH  head entry op_code
out_val  out  VALUE_WIDTH  head entry alu_out
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: at least one sample dropped since last rst/clr
drop_cnt  out  DROP_WIDTH  dropped samples, saturates at all-ones

Behaviour:
- Reset / clr:
  - Priority is rst = clr > pop/push.
  - Both clear out_valid, level, overflow, drop_cnt and the seq counter to 0.
  - out_seq, out_op and out_val read 0 when empty after reset.
  - clr discards all buffered entries in one cycle, including any in-flight push or pop.
- Sample:
  - A cycle qualifies when trace_en=1 and !(FILTER_NOP && op_code==NOP_CODE).
  - Sampled on the rising clk edge.
- Seq counter:
  - Increments by 1 on every qualifying sample, whether stored or dropped.
  - Gaps in out_seq therefore expose drops.
  - The stored stamp is the counter value before the increment, so the first sample gets seq 0.
  - Wraps from 2^SEQ_WIDTH-1 to 0.
- Push: a qualifying sample is stored if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
- Drop:
  - A qualifying sample is dropped if level==DEPTH with no pop that cycle.
  - On a drop, overflow is set and drop_cnt increments, saturating at all-ones.
- Pop: occurs when out_valid && out_ready at the rising edge; the head advances.
- Latency:
  - A sample pushed into an empty FIFO at edge N gives out_valid=1 with its data after edge N (one cycle).
  - There is no combinational path from op_code/alu_out to the out_* ports.
- Simultaneous push and pop: level is unchanged; allowed at any level, including full and 1.
  - At level 1, the popped entry is replaced by the new one on the next cycle; out_valid stays 1.
- Out port stability: out_seq, out_op and out_val are stable while out_valid=1 && out_ready=0.
- out_valid equals (level != 0), registered.
- Storage: circular buffer with log2(DEPTH)-bit read/write pointers that wrap naturally; full/empty are derived from level.
- trace_en=0: no sampling; draining continues normally.
- Reset mid-drain: the entry being popped in the reset cycle is lost; no partial state survives.

Test Plan:
1. Basic latency: rst 2 cycles; trace_en=1, out_ready=1; drive op_code=3, alu_out=0x5A for one cycle -> next cycle out_valid=1, out_seq=0, out_op=3, out_val=0x5A; following cycle out_valid=0, level=0.
2. NOP filter: FILTER_NOP=1; drive op_code sequence 0,4,0,7 with out_ready=1 -> only two entries emerge: (seq 0, op 4) and (seq 1, op 7); overflow=0.
3. Overflow: DEPTH=16, out_ready=0, 20 qualifying samples with alu_out=0..19 -> level=16, overflow=1, drop_cnt=4; drain yields alu 0..15 with seq 0..15; later samples carry seq 20 onward.
4. Full with concurrent pop: fill to 16; hold out_ready=1 while sampling continuously for 10 cycles -> drop_cnt unchanged, level stays 16, output seq strictly increments by 1.
5. Backpressure hold: 3 entries buffered; toggle out_ready 0/1 every other cycle -> out_* constant while ready=0; entries delivered in order with no duplicates.
6. clr and wrap: SEQ_WIDTH=4; sample 18 cycles while draining -> seq goes 14,15,0,1; assert clr mid-stream -> next cycle level=0, out_valid=0, overflow=0, drop_cnt=0; next sample seq=0.

Source files
------------

// File: rtl/proc_trace_buf.sv
// Hardware trace buffer for the proc core: stamps qualifying op_code/alu_out cycles
// into a circular FIFO and drains them on a valid/ready port, counting lost samples.
module proc_trace_buf #(
  parameter int                      OPCODE_WIDTH = 5,
  parameter int                      VALUE_WIDTH  = 8,
  parameter int                      DEPTH        = 16,
  parameter int                      SEQ_WIDTH    = 16,
  parameter int                      DROP_WIDTH   = 8,
  parameter bit                      FILTER_NOP   = 1'b1,
  parameter logic [OPCODE_WIDTH-1:0] NOP_CODE     = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trace_en,
  input  logic                       clr,
  input  logic [OPCODE_WIDTH-1:0]    op_code,
  input  logic [VALUE_WIDTH-1:0]     alu_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEQ_WIDTH-1:0]       out_seq,
  output logic [OPCODE_WIDTH-1:0]    out_op,
  output logic [VALUE_WIDTH-1:0]     out_val,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [DROP_WIDTH-1:0]      drop_cnt
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [SEQ_WIDTH-1:0]    seq;
    logic [OPCODE_WIDTH-1:0] op;
    logic [VALUE_WIDTH-1:0]  val;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [PTR_W-1:0]     wptr;
  logic [PTR_W-1:0]     rptr;
  logic [SEQ_WIDTH-1:0] seq_cnt;
  logic [LVL_W-1:0]     level_nxt;
  logic                 flush;
  logic                 qualify;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  // Sample qualification and FIFO handshake decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    flush   = rst | clr;
    qualify = trace_en & ~(FILTER_NOP & (op_code == NOP_CODE));
    full    = (level == FULL_LVL);
    pop     = out_valid & out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    push    = qualify & (~full | pop);
    drop    = qualify & full & ~pop;
  end

  always_comb begin
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Control state: pointers, occupancy, stamp counter and drop accounting.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      seq_cnt   <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      // Stamps advance on drops too, so gaps in out_seq reveal lost entries.
      if (qualify) seq_cnt <= seq_cnt + SEQ_WIDTH'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (~&drop_cnt) drop_cnt <= drop_cnt + DROP_WIDTH'(1);
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; pointers and level alone define validity.
    if (push && !flush) begin
      mem[wptr] <= '{seq: seq_cnt, op: op_code, val: alu_out};
    end
  end

  // Head is read straight from registered storage, and forced to zero when empty.
  always_comb begin
    out_seq = '0;
    out_op  = '0;
    out_val = '0;
    if (out_valid) begin
      out_seq = mem[rptr].seq;
      out_op  = mem[rptr].op;
      out_val = mem[rptr].val;
    end
  end

endmodule
